relu_drain_ctrl: RTL and testbench
==================================

# relu_drain_ctrl

Sequences the drain of a completed accumulator tile through the column ReLU array. The controller reads one accumulator row per cycle (COL × 32-bit) from the accumulator buffer and presents it to the ReLU array with per-column valids. It collects the ReLU outputs into a small row FIFO and delivers packed 8-bit rows downstream over a valid/ready handshake. A credit scheme prevents FIFO overflow under backpressure, so reads never have to be cancelled.

## Interface
Parameters:
- COL, 3, number of columns.
- W_DATA, 8, ReLU output width per column.
- ROWS_W, 8, width of the row count and address.
- FIFO_DEPTH, 4, output row FIFO entries; power of two, ≥ 4.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_num_rows  in  ROWS_W  rows to drain; sampled with i_start.
- i_col_mask  in  COL  column enable, bit i = column i; sampled with i_start.
- o_busy  out  1  high from the cycle after start until o_done.
- o_done  out  1  one-cycle pulse at completion.
- o_err  out  1  sticky partial-valid error; cleared by i_start or reset.
- o_acc_rd_en  out  1  accumulator read strobe.
- o_acc_rd_addr  out  ROWS_W  row address.
- i_acc_rd_data  in  COL*32  read data, valid one cycle after o_acc_rd_en.
- o_relu_valid  out  COL  to the ReLU array's i_data_valid.
- o_relu_data  out  COL*32  to the ReLU array's i_data.
- i_relu_valid  in  COL  from the ReLU array's o_data_valid.
- i_relu_data  in  COL*W_DATA  from the ReLU array's o_data.
- o_row_valid  out  1  packed row available.
- o_row_data  out  COL*W_DATA  packed row.
- i_row_ready  in  1  downstream accept.

## Operation
- Column packing:
  - Column i occupies bits [32*(COL-i)-1 -: 32] of 32-bit buses and [W_DATA*(COL-i)-1 -: W_DATA] of W_DATA buses, so column 0 is in the MSBs.
  - Valid/mask bit i corresponds to column i.
- FSM states:
  - IDLE: i_start latches the row count and mask and clears o_err. If the row count is 0, go to DONE; otherwise go to DRAIN.
  - DRAIN: issue a read when credit is available. The address increments from 0 to N-1. After read N-1 is issued, go to FLUSH.
  - FLUSH: wait until the in-flight count is 0, the FIFO is empty, and N rows have been popped. Then go to DONE.
  - DONE: assert o_done for one cycle, then go to IDLE.
- Credit rule: issue a read only if fifo_count + inflight < FIFO_DEPTH. inflight counts reads issued but not yet pushed into the FIFO (maximum 2).
- ReLU feed:
  - o_relu_data = i_acc_rd_data, passed through combinationally.
  - o_relu_valid = (o_acc_rd_en delayed by 1 cycle) replicated across COL bits, ANDed with the mask.
- FIFO push condition: (i_relu_valid & mask) == mask, with the mask nonzero. Masked-off columns are written as 0.
- Partial valid: if (i_relu_valid & mask) is neither 0 nor the full mask, set o_err, push nothing, and decrement inflight.
- All-zero mask: rows are still read and counted, and every pushed row is all zeros. For this case the push condition is the delayed read strobe.
- Pop: a FIFO entry is popped on o_row_valid && i_row_ready. o_row_data is the FIFO head and is held stable while i_row_ready is low.
- A start received while busy is ignored.

## Timing
- Reset values: FSM in IDLE, FIFO empty, counters 0. o_busy, o_done, o_err, o_acc_rd_en, o_relu_valid and o_row_valid are all 0. o_acc_rd_addr and o_row_data are 0.
- Pipeline latency for a read issued at cycle t:
  - data is valid at t+1;
  - the ReLU output and FIFO push occur at t+2;
  - o_row_valid rises at t+3 if the FIFO was empty.
- Throughput: with i_row_ready held high, the block sustains one row per cycle.
- Completion timing:
  - o_done rises the cycle after the last pop handshake;
  - o_busy falls in the same cycle o_done rises.
  - For N = 0, o_done is at start+1 and no reads are issued.
- Simultaneous push and pop: fifo_count is unchanged.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH.
- Full FIFO: the credit rule makes overflow unreachable. An assertion checks this.
- Reset mid-operation: everything returns to reset values immediately. In-flight rows are discarded.

## Structure
- Package relu_drain_pkg holds:
  - ACC_W = 32;
  - RD_LAT = 1 and RELU_LAT = 1, which together set the inflight bound of RD_LAT + RELU_LAT;
  - the FSM state enum {IDLE, DRAIN, FLUSH, DONE}.
- One sub-module: relu_row_fifo, a synchronous FIFO of width COL*W_DATA and depth FIFO_DEPTH with count output.

## Test plan
- N=5, mask=3'b111, ready always 1 → reads at addresses 0–4 on consecutive cycles; 5 rows out on consecutive cycles starting at start+4; o_done one cycle after the 5th pop.
- N=8, ready held low → reads stop after 4 credits are used (addresses 0–3) and fifo_count = 4. Raising ready resumes reads; all 8 rows are delivered in order with no loss.
- Column 1 accumulator = 0xFFFF_FF80, mask=3'b101 → the column-1 byte is 0x00 and the other columns carry the ReLU results; o_err = 0.
- Force i_relu_valid = 3'b011 with mask 3'b111 → o_err = 1, the row is dropped, and o_done still fires. The next i_start clears o_err.
- i_start with N=0 → o_done at start+1, no o_acc_rd_en.
- i_rst asserted at the 3rd row of N=6 → all outputs are 0 asynchronously, the FIFO is empty, and a new start behaves as from power-up.

Source files
------------

// File: rtl/relu_drain_pkg.sv
// Shared constants and FSM state type for the ReLU drain controller.
// Latency constants describe the accumulator read and ReLU array pipelines.
// The inflight bound is derived from those two latencies.
package relu_drain_pkg;
  localparam int ACC_W        = 32;
  localparam int RD_LAT       = 1;
  localparam int RELU_LAT     = 1;
  localparam int MAX_INFLIGHT = RD_LAT + RELU_LAT;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH, DONE} state_t;
endpackage

// File: rtl/relu_drain_ctrl_if.sv
// Bundle of control, accumulator, ReLU and row-output signals of the drain controller.
// Pure wiring, no latency.
// Row output uses valid/ready; master side is the controller.
interface relu_drain_ctrl_if #(
  parameter int COL    = 3,
  parameter int W_DATA = 8,
  parameter int ROWS_W = 8
);
  import relu_drain_pkg::*;

  logic                    i_start;
  logic [ROWS_W-1:0]       i_num_rows;
  logic [COL-1:0]          i_col_mask;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_err;
  logic                    o_acc_rd_en;
  logic [ROWS_W-1:0]       o_acc_rd_addr;
  logic [COL*ACC_W-1:0]    i_acc_rd_data;
  logic [COL-1:0]          o_relu_valid;
  logic [COL*ACC_W-1:0]    o_relu_data;
  logic [COL-1:0]          i_relu_valid;
  logic [COL*W_DATA-1:0]   i_relu_data;
  logic                    o_row_valid;
  logic [COL*W_DATA-1:0]   o_row_data;
  logic                    i_row_ready;

  modport master (
    input  i_start, i_num_rows, i_col_mask, i_acc_rd_data,
           i_relu_valid, i_relu_data, i_row_ready,
    output o_busy, o_done, o_err, o_acc_rd_en, o_acc_rd_addr,
           o_relu_valid, o_relu_data, o_row_valid, o_row_data
  );

  modport slave (
    output i_start, i_num_rows, i_col_mask, i_acc_rd_data,
           i_relu_valid, i_relu_data, i_row_ready,
    input  o_busy, o_done, o_err, o_acc_rd_en, o_acc_rd_addr,
           o_relu_valid, o_relu_data, o_row_valid, o_row_data
  );
endinterface

// File: rtl/relu_row_fifo.sv
// Synchronous row FIFO with occupancy count; head is zero while empty.
// Push-to-valid latency 1 cycle; pop and push in the same cycle keep the count.
// No internal backpressure: the writer must guarantee space (checked by assertion).
module relu_row_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  // Pointer and count update; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    pop_ok   = i_pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(i_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(i_push) - CNT_W'(pop_ok);
  end

  // Pointer/count state with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage; contents need no reset because the head is gated by occupancy.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_valid = (count_q != '0);
  assign o_head  = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    i_push |-> (count_q < CNT_W'(DEPTH)));
endmodule

// File: rtl/relu_drain_ctrl.sv
// Drains an accumulator tile row by row through the ReLU array into a row FIFO.
// Read at t -> ReLU input t+1 -> FIFO push t+2 -> o_row_valid t+3 (empty FIFO).
// Reads are credit-gated on FIFO space, so downstream stalls never drop or cancel a row.
module relu_drain_ctrl
  import relu_drain_pkg::*;
#(
  parameter int COL        = 3,
  parameter int W_DATA     = 8,
  parameter int ROWS_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  relu_drain_ctrl_if.master bus
);
  localparam int ROW_BITS = COL * W_DATA;
  localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int IF_W     = $clog2(MAX_INFLIGHT + 1);
  localparam int SUM_W    = CNT_W + 1;

  state_t             state_q, state_d;
  logic [ROWS_W-1:0]  num_rows_q, num_rows_d;
  logic [ROWS_W-1:0]  rd_addr_q, rd_addr_d;
  logic [ROWS_W-1:0]  retired_q, retired_d;
  logic [COL-1:0]     mask_q, mask_d;
  logic               err_q, err_d;
  logic               rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
  logic [IF_W-1:0]    inflight_q, inflight_d;

  logic               rd_en, credit_ok, push, drop, pop, row_live;
  logic [COL-1:0]     masked_vld;
  logic [ROW_BITS-1:0] push_dat, fifo_head;
  logic [CNT_W-1:0]   fifo_cnt, fifo_cnt_nxt;
  logic               fifo_vld;

  assign credit_ok = (SUM_W'(fifo_cnt) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
  assign pop       = fifo_vld && bus.i_row_ready;

  // Classify the ReLU output row: full-mask push, partial drop, or zero-mask push from
  // the twice-delayed read strobe; masked-off columns are forced to zero.
  always_comb begin
    masked_vld = bus.i_relu_valid & mask_q;
    row_live   = (state_q == DRAIN) || (state_q == FLUSH);
    push       = 1'b0;
    drop       = 1'b0;
    push_dat   = '0;
    if (row_live) begin
      if (mask_q == '0) begin
        push = rd_p2_q;
      end else begin
        push = (masked_vld == mask_q);
        drop = (masked_vld != '0) && (masked_vld != mask_q);
      end
    end
    for (int c = 0; c < COL; c++) begin
      push_dat[W_DATA*(COL-c)-1 -: W_DATA] =
        mask_q[c] ? bus.i_relu_data[W_DATA*(COL-c)-1 -: W_DATA] : '0;
    end
  end

  // FSM next state plus counters; FLUSH exits on post-update values so o_done
  // lands the cycle right after the final pop. Dropped rows count as retired.
  always_comb begin
    state_d      = state_q;
    num_rows_d   = num_rows_q;
    mask_d       = mask_q;
    rd_addr_d    = rd_addr_q;
    rd_en        = (state_q == DRAIN) && credit_ok;
    rd_p1_d      = rd_en;
    rd_p2_d      = rd_p1_q;
    inflight_d   = inflight_q + IF_W'(rd_en) - IF_W'(push || drop);
    retired_d    = retired_q + ROWS_W'(pop) + ROWS_W'(drop);
    err_d        = err_q || drop;
    fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          num_rows_d = bus.i_num_rows;
          mask_d     = bus.i_col_mask;
          err_d      = 1'b0;
          rd_addr_d  = '0;
          retired_d  = '0;
          state_d    = (bus.i_num_rows == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (rd_en) begin
          rd_addr_d = rd_addr_q + ROWS_W'(1);
          if (rd_addr_q == num_rows_q - ROWS_W'(1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if ((inflight_d == '0) && (fifo_cnt_nxt == '0) && (retired_d == num_rows_q))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state register with asynchronous reset; discards in-flight rows.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      num_rows_q <= '0;
      mask_q     <= '0;
      rd_addr_q  <= '0;
      retired_q  <= '0;
      err_q      <= 1'b0;
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      mask_q     <= mask_d;
      rd_addr_q  <= rd_addr_d;
      retired_q  <= retired_d;
      err_q      <= err_d;
      rd_p1_q    <= rd_p1_d;
      rd_p2_q    <= rd_p2_d;
      inflight_q <= inflight_d;
    end
  end

  relu_row_fifo #(
    .WIDTH (ROW_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_dat),
    .i_pop       (pop),
    .o_valid     (fifo_vld),
    .o_head      (fifo_head),
    .o_count     (fifo_cnt)
  );

  assign bus.o_busy        = (state_q == DRAIN) || (state_q == FLUSH);
  assign bus.o_done        = (state_q == DONE);
  assign bus.o_err         = err_q;
  assign bus.o_acc_rd_en   = rd_en;
  assign bus.o_acc_rd_addr = rd_addr_q;
  assign bus.o_relu_data   = bus.i_acc_rd_data;
  assign bus.o_relu_valid  = {COL{rd_p1_q}} & mask_q;
  assign bus.o_row_valid   = fifo_vld;
  assign bus.o_row_data    = fifo_head;

  a_inflight_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    inflight_q <= IF_W'(MAX_INFLIGHT));
endmodule

// File: tb/tb_relu_drain_ctrl.sv
module tb_relu_drain_ctrl;
  localparam int COL = 3, W = 8, RW = 8, DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  relu_drain_ctrl_if #(.COL(COL), .W_DATA(W), .ROWS_W(RW)) bus ();

  relu_drain_ctrl #(.COL(COL), .W_DATA(W), .ROWS_W(RW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [95:0] acc_mem [16];
  int          relu_seen;
  int          corrupt_idx = -1;
  int          rd_addr_log[$];
  int          rd_cyc_log[$];
  int          pop_cyc_log[$];
  logic [23:0] pop_dat_log[$];

  function automatic logic [7:0] relu8(input logic [31:0] x);
    if (x[31]) return 8'h00;
    else if (x > 32'd255) return 8'hFF;
    else return x[7:0];
  endfunction

  // row r: col0 = r+1, col1 = 0x100+r (even r) or -16 (odd r), col2 = 0x40+r
  function automatic logic [95:0] acc_row(input int r);
    logic [31:0] c1;
    c1 = (r % 2 == 0) ? (32'h100 + 32'(r)) : 32'hFFFF_FFF0;
    return {32'(r + 1), c1, 32'h40 + 32'(r)};
  endfunction

  function automatic logic [23:0] exp_row(input int r, input logic [2:0] m);
    logic [7:0] b0, b1, b2;
    b0 = 8'(r + 1);
    b1 = (r % 2 == 0) ? 8'hFF : 8'h00;
    b2 = 8'(32'h40 + 32'(r));
    return {m[0] ? b0 : 8'h00, m[1] ? b1 : 8'h00, m[2] ? b2 : 8'h00};
  endfunction

  // accumulator buffer model, one-cycle read latency
  always @(posedge clk or posedge rst) begin
    if (rst) bus.i_acc_rd_data <= '0;
    else if (bus.o_acc_rd_en) bus.i_acc_rd_data <= acc_mem[bus.o_acc_rd_addr[3:0]];
  end

  // ReLU array model, one-cycle latency, optional corrupted valid on one row
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.i_relu_valid <= '0;
      bus.i_relu_data  <= '0;
      relu_seen        <= 0;
    end else begin
      bus.i_relu_valid <= ((bus.o_relu_valid != '0) && (relu_seen == corrupt_idx)) ? 3'b011 : bus.o_relu_valid;
      for (int c = 0; c < COL; c++)
        bus.i_relu_data[W*(COL-c)-1 -: W] <= relu8(bus.o_relu_data[32*(COL-c)-1 -: 32]);
      if (bus.o_relu_valid != '0) relu_seen <= relu_seen + 1;
    end
  end

  // transaction logs
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.o_acc_rd_en) begin
        rd_addr_log.push_back(int'(bus.o_acc_rd_addr));
        rd_cyc_log.push_back(cyc);
      end
      if (bus.o_row_valid && bus.i_row_ready) begin
        pop_dat_log.push_back(bus.o_row_data);
        pop_cyc_log.push_back(cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input int n, input logic [2:0] m, output int s);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_num_rows = 8'(n);
    bus.i_col_mask = m;
    s = cyc;
    @(negedge clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (bus.o_done) begin
        dc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},      32'(bus.o_busy), 32'd0);
    chk({tag, "_done"},      32'(bus.o_done), 32'd0);
    chk({tag, "_err"},       32'(bus.o_err), 32'd0);
    chk({tag, "_rd_en"},     32'(bus.o_acc_rd_en), 32'd0);
    chk({tag, "_rd_addr"},   32'(bus.o_acc_rd_addr), 32'd0);
    chk({tag, "_relu_vld"},  32'(bus.o_relu_valid), 32'd0);
    chk({tag, "_row_vld"},   32'(bus.o_row_valid), 32'd0);
    chk({tag, "_row_dat"},   32'(bus.o_row_data), 32'd0);
  endtask

  // N=5, full mask, ready high: back-to-back reads and pops with fixed latency
  task automatic run_n5(input string tag);
    int s, dc, rb, pb;
    rb = rd_addr_log.size();
    pb = pop_dat_log.size();
    bus.i_row_ready = 1'b1;
    start_op(5, 3'b111, s);
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
    wait_done(60, dc);
    chk({tag, "_done_cyc"}, 32'(dc - s), 32'd9);
    chk({tag, "_busy_at_done"}, 32'(bus.o_busy), 32'd0);
    chk({tag, "_nrd"}, 32'(rd_addr_log.size() - rb), 32'd5);
    chk({tag, "_npop"}, 32'(pop_dat_log.size() - pb), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (rb + k < rd_addr_log.size()) begin
        chk({tag, "_rd_addr"}, 32'(rd_addr_log[rb+k]), 32'(k));
        chk({tag, "_rd_cyc"}, 32'(rd_cyc_log[rb+k] - s), 32'(1 + k));
      end
      if (pb + k < pop_dat_log.size()) begin
        chk({tag, "_pop_dat"}, 32'(pop_dat_log[pb+k]), 32'(exp_row(k, 3'b111)));
        chk({tag, "_pop_cyc"}, 32'(pop_cyc_log[pb+k] - s), 32'(4 + k));
      end
    end
    chk({tag, "_err"}, 32'(bus.o_err), 32'd0);
  endtask

  initial begin
    int s, dc, rb, pb;
    for (int r = 0; r < 16; r++) acc_mem[r] = acc_row(r);
    bus.i_start     = 1'b0;
    bus.i_num_rows  = '0;
    bus.i_col_mask  = '0;
    bus.i_row_ready = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
    rst = 1'b0;

    // streaming at full rate
    run_n5("n5");

    // backpressure: credits stop reads at 4, then everything drains in order
    rb = rd_addr_log.size();
    pb = pop_dat_log.size();
    bus.i_row_ready = 1'b0;
    start_op(8, 3'b111, s);
    bus.i_start    = 1'b1;   // start while busy must be ignored
    bus.i_num_rows = 8'd1;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(negedge clk);
    chk("bp_nrd_stalled", 32'(rd_addr_log.size() - rb), 32'd4);
    chk("bp_last_addr", 32'(rd_addr_log[rd_addr_log.size()-1]), 32'd3);
    chk("bp_fifo_cnt", 32'(dut.fifo_cnt), 32'd4);
    chk("bp_row_vld", 32'(bus.o_row_valid), 32'd1);
    chk("bp_head", 32'(bus.o_row_data), 32'(exp_row(0, 3'b111)));
    @(negedge clk);
    chk("bp_head_hold", 32'(bus.o_row_data), 32'(exp_row(0, 3'b111)));
    bus.i_row_ready = 1'b1;
    wait_done(100, dc);
    chk("bp_done_seen", 32'(dc >= 0), 32'd1);
    chk("bp_nrd", 32'(rd_addr_log.size() - rb), 32'd8);
    chk("bp_npop", 32'(pop_dat_log.size() - pb), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (pb + k < pop_dat_log.size())
        chk("bp_pop_dat", 32'(pop_dat_log[pb+k]), 32'(exp_row(k, 3'b111)));
    end

    // column mask 101 with negative column-1 accumulator
    acc_mem[0][63:32] = 32'hFFFF_FF80;
    pb = pop_dat_log.size();
    start_op(2, 3'b101, s);
    @(negedge clk);
    chk("mask_relu_vld", 32'(bus.o_relu_valid), 32'h5);
    chk("mask_relu_dat_c1", bus.o_relu_data[63:32], 32'hFFFF_FF80);
    wait_done(60, dc);
    chk("mask_npop", 32'(pop_dat_log.size() - pb), 32'd2);
    if (pb + 1 < pop_dat_log.size()) begin
      chk("mask_row0", 32'(pop_dat_log[pb]), 32'h010040);
      chk("mask_row1", 32'(pop_dat_log[pb+1]), 32'h020041);
    end
    chk("mask_err", 32'(bus.o_err), 32'd0);
    acc_mem[0] = acc_row(0);

    // partial valid on the second row: dropped, error sticky, done still fires
    pb = pop_dat_log.size();
    corrupt_idx = relu_seen + 1;
    start_op(3, 3'b111, s);
    wait_done(60, dc);
    corrupt_idx = -1;
    chk("part_done_seen", 32'(dc >= 0), 32'd1);
    chk("part_err", 32'(bus.o_err), 32'd1);
    chk("part_npop", 32'(pop_dat_log.size() - pb), 32'd2);
    if (pb + 1 < pop_dat_log.size()) begin
      chk("part_row0", 32'(pop_dat_log[pb]), 32'(exp_row(0, 3'b111)));
      chk("part_row2", 32'(pop_dat_log[pb+1]), 32'(exp_row(2, 3'b111)));
    end
    repeat (3) @(negedge clk);
    chk("part_err_sticky", 32'(bus.o_err), 32'd1);

    // N=0: immediate done, no reads, error cleared by the start
    rb = rd_addr_log.size();
    start_op(0, 3'b111, s);
    wait_done(10, dc);
    chk("n0_done_cyc", 32'(dc - s), 32'd1);
    chk("n0_err_cleared", 32'(bus.o_err), 32'd0);
    chk("n0_busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    chk("n0_nrd", 32'(rd_addr_log.size() - rb), 32'd0);

    // all-zero mask: rows still read and delivered as zeros
    rb = rd_addr_log.size();
    pb = pop_dat_log.size();
    start_op(2, 3'b000, s);
    wait_done(60, dc);
    chk("zm_done_seen", 32'(dc >= 0), 32'd1);
    chk("zm_nrd", 32'(rd_addr_log.size() - rb), 32'd2);
    chk("zm_npop", 32'(pop_dat_log.size() - pb), 32'd2);
    if (pb + 1 < pop_dat_log.size()) begin
      chk("zm_row0", 32'(pop_dat_log[pb]), 32'd0);
      chk("zm_row1", 32'(pop_dat_log[pb+1]), 32'd0);
    end

    // asynchronous reset in the middle of an N=6 drain
    rb = rd_addr_log.size();
    start_op(6, 3'b111, s);
    for (int i = 0; i < 20 && (rd_addr_log.size() - rb) < 3; i++) @(negedge clk);
    chk("rst_third_read", 32'(rd_addr_log.size() - rb), 32'd3);
    chk("rst_pre_row_vld", 32'(bus.o_row_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    chk("midrst_fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_row_vld", 32'(bus.o_row_valid), 32'd0);
    run_n5("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
